// File: rtl/imem_loadable.sv
// Instruction memory with a registered fetch port and a byte-serial program loader.
// The loader rewrites memory word by word and holds the core while it is active.
module imem_loadable #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      DEPTH     = 1024,
  parameter logic [XLEN-1:0]  BASE_ADDR = 32'h0000_0000,
  parameter string            INIT_FILE = "",
  parameter logic [XLEN-1:0]  NOP_WORD  = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_stall,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  output logic [1:0]      if_fault,
  input  logic            ld_start,
  input  logic            ld_valid,
  input  logic [7:0]      ld_byte,
  input  logic            ld_end,
  output logic            ld_ready,
  output logic            ld_overflow,
  output logic            core_hold
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  logic [31:0]     mem [DEPTH];

  state_e          state_q, state_d;
  logic [AW:0]     ptr_q, ptr_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     asm_q, asm_d;
  logic            ovf_q, ovf_d;
  logic            ready_q, hold_q;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            valid_q, valid_d;
  logic [1:0]      fault_q, fault_d;

  logic [1:0]      bcnt_nx_s;
  logic            ptr_full_s;
  logic            mem_we_s;
  logic [AW-1:0]   mem_waddr_s;
  logic [31:0]     mem_wdata_s;
  logic [31:0]     flush_word_s;
  logic [XLEN-1:0] off_s;
  logic            mis_s, oor_s;

  // Loader next-state: byte assembly, word writes, end/flush handling.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    bcnt_d      = bcnt_q;
    asm_d       = asm_q;
    ovf_d       = ovf_q;
    bcnt_nx_s   = bcnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = ptr_q[AW-1:0];
    mem_wdata_s = {ld_byte, asm_q};
    ptr_full_s  = (ptr_q == (AW+1)'(DEPTH));

    case (bcnt_q)
      2'd1:    flush_word_s = {24'd0, asm_q[7:0]};
      2'd2:    flush_word_s = {16'd0, asm_q[15:0]};
      2'd3:    flush_word_s = {8'd0, asm_q};
      default: flush_word_s = 32'd0;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = {(AW+1){1'b0}};
          bcnt_d  = 2'd0;
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (ld_start) begin
          state_d = ST_LOAD;
          ptr_d   = {(AW+1){1'b0}};
          bcnt_d  = 2'd0;
          ovf_d   = 1'b0;
        end else begin
          if (ld_valid) begin
            if (ptr_full_s) begin
              ovf_d = 1'b1;
            end else if (bcnt_q == 2'd3) begin
              mem_we_s  = 1'b1;
              ptr_d     = ptr_q + {{AW{1'b0}}, 1'b1};
              bcnt_nx_s = 2'd0;
            end else begin
              case (bcnt_q)
                2'd0:    asm_d[7:0]   = ld_byte;
                2'd1:    asm_d[15:8]  = ld_byte;
                default: asm_d[23:16] = ld_byte;
              endcase
              bcnt_nx_s = bcnt_q + 2'd1;
            end
          end else begin
            bcnt_nx_s = bcnt_q;
          end
          bcnt_d = bcnt_nx_s;
          // The byte of this cycle is consumed before the end is judged.
          if (ld_end) begin
            state_d = (bcnt_nx_s == 2'd0) ? ST_IDLE : ST_FLUSH;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        mem_we_s    = !ptr_full_s;
        mem_wdata_s = flush_word_s;
        bcnt_d      = 2'd0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Fetch next-state: fault classification, stall hold, blocking during loads.
  always_comb begin
    off_s   = if_addr - BASE_ADDR;
    mis_s   = (if_addr[1:0] != 2'b00);
    oor_s   = ((off_s >> 2) >= XLEN'(DEPTH));
    rdata_d = rdata_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (state_q != ST_IDLE) begin
      rdata_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 2'b00;
    end else if (if_stall) begin
      rdata_d = rdata_q;
    end else if (if_req) begin
      valid_d = 1'b1;
      fault_d = {oor_s, mis_s};
      rdata_d = (mis_s || oor_s) ? NOP_WORD : XLEN'(mem[off_s[AW+1:2]]);
    end else begin
      rdata_d = NOP_WORD;
      valid_d = 1'b0;
      fault_d = 2'b00;
    end
  end

  // Memory write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= {(AW+1){1'b0}};
      bcnt_q  <= 2'd0;
      asm_q   <= 24'd0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      hold_q  <= 1'b0;
      rdata_q <= NOP_WORD;
      valid_q <= 1'b0;
      fault_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      ready_q <= (state_d == ST_LOAD);
      hold_q  <= (state_d != ST_IDLE);
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign if_rdata    = rdata_q;
  assign if_valid    = valid_q;
  assign if_fault    = fault_q;
  assign ld_ready    = ready_q;
  assign ld_overflow = ovf_q;
  assign core_hold   = hold_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Scoreboard bench: a 1024-word instance at base 0 and a 16-word instance at base 0x1000
// share all inputs; fetch expectations are queued when driven and compared on output.
module tb_imem_loadable;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n, if_req, if_stall, ld_start, ld_valid, ld_end;
  logic [31:0] if_addr;
  logic [7:0]  ld_byte;

  logic [31:0] rd_b, rd_s;
  logic        v_b, v_s, rdy_b, rdy_s, ovf_b, ovf_s, hold_b, hold_s;
  logic [1:0]  f_b, f_s;

  typedef struct {
    logic [31:0] rd_b; logic v_b; logic [1:0] f_b;
    logic [31:0] rd_s; logic v_s; logic [1:0] f_s;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_exp;
  logic [31:0] mdl_b [1024];
  logic [31:0] mdl_s [16];
  int          checks_cnt = 0;
  int          fail_cnt   = 0;

  always #5 clk = ~clk;

  imem_loadable #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) u_big (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_rdata(rd_b), .if_valid(v_b), .if_fault(f_b),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_end(ld_end),
    .ld_ready(rdy_b), .ld_overflow(ovf_b), .core_hold(hold_b));

  imem_loadable #(.DEPTH(16), .BASE_ADDR(32'h0000_1000)) u_small (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_stall(if_stall),
    .if_rdata(rd_s), .if_valid(v_s), .if_fault(f_s),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_end(ld_end),
    .ld_ready(rdy_s), .ld_overflow(ovf_s), .core_hold(hold_s));

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic mdl_wr(input int idx, input logic [31:0] w);
    if (idx < 1024) mdl_b[idx] = w;
    if (idx < 16)   mdl_s[idx] = w;
  endtask

  function automatic exp_t predict(input logic [31:0] a);
    exp_t e;
    logic [31:0] ob, os;
    ob = a - 32'h0000_0000;
    os = a - 32'h0000_1000;
    e.v_b  = 1'b1;
    e.f_b  = {((ob >> 2) >= 32'd1024), (a[1:0] != 2'b00)};
    e.rd_b = (e.f_b != 2'b00) ? NOP : mdl_b[ob[11:2]];
    e.v_s  = 1'b1;
    e.f_s  = {((os >> 2) >= 32'd16), (a[1:0] != 2'b00)};
    e.rd_s = (e.f_s != 2'b00) ? NOP : mdl_s[os[5:2]];
    return e;
  endfunction

  task automatic cmp_outputs(input string tag, input exp_t e);
    chk_eq({tag, "_rd_b"}, rd_b, e.rd_b);
    chk_eq({tag, "_v_b"},  {31'd0, v_b}, {31'd0, e.v_b});
    chk_eq({tag, "_f_b"},  {30'd0, f_b}, {30'd0, e.f_b});
    chk_eq({tag, "_rd_s"}, rd_s, e.rd_s);
    chk_eq({tag, "_v_s"},  {31'd0, v_s}, {31'd0, e.v_s});
    chk_eq({tag, "_f_s"},  {30'd0, f_s}, {30'd0, e.f_s});
  endtask

  task automatic fetch(input logic [31:0] a);
    @(negedge clk);
    if_req = 1'b1; if_stall = 1'b0; if_addr = a;
    sb_q.push_back(predict(a));
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      chk_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      last_exp = sb_q.pop_front();
      cmp_outputs("fetch", last_exp);
    end
  endtask

  task automatic ld_go;
    @(negedge clk);
    ld_start = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    ld_start = 1'b0;
    chk_eq("start_hold", {30'd0, hold_b, hold_s}, 32'd3);
    chk_eq("start_rdy",  {30'd0, rdy_b, rdy_s},   32'd3);
    chk_eq("start_ovf",  {30'd0, ovf_b, ovf_s},   32'd0);
  endtask

  task automatic ld_send(input logic [7:0] b, input logic e, input logic exp_hold);
    @(negedge clk);
    ld_valid = 1'b1; ld_byte = b; ld_end = e; if_req = 1'b1; if_addr = 32'h0;
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_end = 1'b0; if_req = 1'b0;
    chk_eq("ld_hold",   {31'd0, hold_b}, {31'd0, exp_hold});
    chk_eq("ld_rdy",    {31'd0, rdy_b},  {31'd0, !e});
    chk_eq("ld_blk_v",  {31'd0, v_b},    32'd0);
    chk_eq("ld_blk_rd", rd_b, NOP);
  endtask

  task automatic ld_finish;
    @(negedge clk);
    ld_end = 1'b1;
    @(posedge clk); #1;
    ld_end = 1'b0;
    chk_eq("end_hold", {30'd0, hold_b, hold_s}, 32'd0);
    chk_eq("end_rdy",  {30'd0, rdy_b, rdy_s},   32'd0);
  endtask

  initial begin
    logic [7:0] prog [12];
    prog = '{8'h13, 8'h08, 8'h80, 8'h02, 8'h93, 8'h08, 8'h40, 8'hFF,
             8'h13, 8'h05, 8'hA0, 8'h00};
    rst_n = 1'b0; if_req = 1'b0; if_stall = 1'b0; if_addr = 32'h0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; ld_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_rd",   rd_b, NOP);
    chk_eq("rst_rd_s", rd_s, NOP);
    chk_eq("rst_v",    {30'd0, v_b, v_s}, 32'd0);
    chk_eq("rst_f",    {28'd0, f_b, f_s}, 32'd0);
    chk_eq("rst_hold", {30'd0, hold_b, hold_s}, 32'd0);
    chk_eq("rst_rdy",  {30'd0, rdy_b, rdy_s}, 32'd0);
    chk_eq("rst_ovf",  {30'd0, ovf_b, ovf_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-word program, then fetches across alignment and range boundaries.
    ld_go();
    for (int i = 0; i < 12; i++) ld_send(prog[i], 1'b0, 1'b1);
    ld_finish();
    mdl_wr(0, 32'h0280_0813);
    mdl_wr(1, 32'hFF40_0893);
    mdl_wr(2, 32'h00A0_0513);
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_0008);
    fetch(32'h0000_0002);
    fetch(32'h0000_1000);
    fetch(32'h0000_1002);
    fetch(32'h0000_1004);
    fetch(32'hFFFF_FFFC);
    fetch(32'h0000_0FFF);

    @(negedge clk);
    if_req = 1'b0;
    @(posedge clk); #1;
    chk_eq("noreq_v",  {30'd0, v_b, v_s}, 32'd0);
    chk_eq("noreq_rd", rd_b, NOP);

    // Stall holds the 0x4 result while the address moves to 0x8.
    fetch(32'h0000_0004);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_stall = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0008;
      @(posedge clk); #1;
      cmp_outputs("stall", last_exp);
    end
    fetch(32'h0000_0008);

    // Partial word via FLUSH; hold falls two cycles after ld_end.
    ld_go();
    ld_send(8'h37, 1'b0, 1'b1);
    ld_send(8'hA4, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk); #1;
    chk_eq("flush_hold", {30'd0, hold_b, hold_s}, 32'd0);
    mdl_wr(0, 32'h0000_A437);
    fetch(32'h0000_0000);
    fetch(32'h0000_0004);
    fetch(32'h0000_1000);

    // 68 bytes: 17 words fit the big instance, the small one drops the last 4 bytes.
    ld_go();
    for (int i = 0; i < 68; i++) ld_send(8'(i), 1'b0, 1'b1);
    ld_finish();
    chk_eq("ovf_s", {31'd0, ovf_s}, 32'd1);
    chk_eq("ovf_b", {31'd0, ovf_b}, 32'd0);
    for (int k = 0; k < 17; k++) mdl_wr(k, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    fetch(32'h0000_003C);
    fetch(32'h0000_0040);
    fetch(32'h0000_103C);
    fetch(32'h0000_1040);
    chk_eq("ovf_sticky", {31'd0, ovf_s}, 32'd1);

    // Reset mid-load drops hold and ready at once; written words survive.
    ld_go();
    ld_send(8'hAA, 1'b0, 1'b1);
    ld_send(8'hBB, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_hold", {30'd0, hold_b, hold_s}, 32'd0);
    chk_eq("mid_rst_rdy",  {30'd0, rdy_b, rdy_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h0000_0000);
    fetch(32'h0000_1000);
    fetch(32'h0000_1004);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
